// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state types for the BCD serial receiver.
//   CLKS_PER_BIT_19200 : bit period in clk cycles for 19200 bps
//   ASCII_CR           : message terminator
//   ASCII_DIGIT_HI     : upper 3 bits of ASCII '0'..'9'
//   bit_state_e        : character deserialiser states
//   msg_state_e        : message assembler states
package uart_pkg;

  localparam int         CLKS_PER_BIT_19200 = 834;
  localparam logic [6:0] ASCII_CR           = 7'h0D;
  localparam logic [2:0] ASCII_DIGIT_HI     = 3'b011;

  typedef enum logic [2:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP,
    BIT_BREAK
  } bit_state_e;

  typedef enum logic [1:0] {
    MSG_WAIT_D1,
    MSG_WAIT_D0,
    MSG_WAIT_CR
  } msg_state_e;

  // ASCII '0'..'9' -> 0x30..0x39
  function automatic logic is_digit(input logic [6:0] c);
    return (c[6:4] == ASCII_DIGIT_HI) && (c[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/uart_bcd_rx_if.sv
// uart_bcd_rx_if: pin/result bundle of the BCD receiver.
//   rx_in     : serial line, idle high
//   bcd1/bcd0 : received tens/units digit
//   valid     : 1-cycle strobe, digits updated
//   frame_err : 1-cycle strobe, stop bit sampled low
//   fmt_err   : 1-cycle strobe, character out of sequence
//   err_cnt   : saturating error count (only with UART_RX_ERRCNT_EN)
// master = receiver side, slave = consumer/line driver side.
interface uart_bcd_rx_if;
  logic       rx_in;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       valid;
  logic       frame_err;
  logic       fmt_err;
`ifdef UART_RX_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  modport master (
    input  rx_in,
`ifdef UART_RX_ERRCNT_EN
    output err_cnt,
`endif
    output bcd1, bcd0, valid, frame_err, fmt_err
  );

  modport slave (
    output rx_in,
`ifdef UART_RX_ERRCNT_EN
    input  err_cnt,
`endif
    input  bcd1, bcd0, valid, frame_err, fmt_err
  );
endinterface

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 2-flop synchroniser + start/data/stop bit deserialiser.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rx_in        : asynchronous serial line, idle high
//   byte_o       : last received character (LSB first on the line)
//   byte_vld_o   : 1-cycle pulse, byte_o holds a good character
//   frame_err_o  : 1-cycle pulse, stop bit sampled low
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_19200,
  parameter int DATA_BITS    = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 byte_vld_o,
  output logic                 frame_err_o
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LAST    = CW'(DATA_BITS - 1);

  logic                 s1_q, s2_q;
  bit_state_e           state_q, state_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 byte_vld_q, byte_vld_d;
  logic                 frame_err_q, frame_err_d;

  logic rx_s;
  assign rx_s = s2_q;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      BIT_IDLE: begin
        if (!rx_s) begin
          state_d = BIT_START;
          tmr_d   = '0;
        end
      end
      // Mid-start-bit recheck rejects line glitches without flagging an error.
      BIT_START: begin
        if (tmr_q == HALF_M1) begin
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = rx_s ? BIT_IDLE : BIT_DATA;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      BIT_DATA: begin
        if (tmr_q == FULL_M1) begin
          tmr_d = '0;
          sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = BIT_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      // Leaving STOP straight to IDLE lets a zero-gap start bit be seen next cycle.
      BIT_STOP: begin
        if (tmr_q == FULL_M1) begin
          tmr_d = '0;
          if (rx_s) begin
            byte_vld_d = 1'b1;
            state_d    = BIT_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BIT_BREAK;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      // Hold off until the line returns high so a break is not taken as a start.
      BIT_BREAK: begin
        if (rx_s) state_d = BIT_IDLE;
      end
      default: state_d = BIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      state_q     <= BIT_IDLE;
      tmr_q       <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      s1_q        <= rx_in;
      s2_q        <= s1_q;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign byte_o      = sh_q;
  assign byte_vld_o  = byte_vld_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/uart_bcd_rx.sv
// uart_bcd_rx: receives {ASCII tens, ASCII units, CR} messages and presents
// the two BCD digits with a 1-cycle valid strobe.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_bcd_rx_if.master (rx_in in; bcd1, bcd0, valid,
//              frame_err, fmt_err out; err_cnt out when enabled)
// Optional feature: define UART_RX_ERRCNT_EN to add an 8-bit saturating
// count of error pulses on bus.err_cnt.
module uart_bcd_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_19200,
  parameter int DATA_BITS    = 7
) (
  input  logic           clk,
  input  logic           rst,
  uart_bcd_rx_if.master  bus
);

  logic [DATA_BITS-1:0] byte_w;
  logic                 byte_vld_w;
  logic                 frame_err_w;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (bus.rx_in),
    .byte_o      (byte_w),
    .byte_vld_o  (byte_vld_w),
    .frame_err_o (frame_err_w)
  );

  msg_state_e msg_q, msg_d;
  logic [3:0] d1_q, d1_d;
  logic [3:0] d0_q, d0_d;
  logic [3:0] bcd1_q, bcd1_d;
  logic [3:0] bcd0_q, bcd0_d;
  logic       valid_q, valid_d;
  logic       fmt_err_q, fmt_err_d;

  logic [6:0] ch;
  logic       ch_digit, ch_cr;
  assign ch       = byte_w[6:0];
  assign ch_digit = is_digit(ch);
  assign ch_cr    = (ch == ASCII_CR);

  always_comb begin
    msg_d     = msg_q;
    d1_d      = d1_q;
    d0_d      = d0_q;
    bcd1_d    = bcd1_q;
    bcd0_d    = bcd0_q;
    valid_d   = 1'b0;
    fmt_err_d = 1'b0;
    if (frame_err_w) begin
      // Corrupt character: drop whatever was assembled so far.
      msg_d = MSG_WAIT_D1;
    end else if (byte_vld_w) begin
      case (msg_q)
        MSG_WAIT_D1: begin
          if (ch_digit) begin
            d1_d  = ch[3:0];
            msg_d = MSG_WAIT_D0;
          end else begin
            fmt_err_d = 1'b1;
            msg_d     = MSG_WAIT_D1;
          end
        end
        MSG_WAIT_D0: begin
          if (ch_digit) begin
            d0_d  = ch[3:0];
            msg_d = MSG_WAIT_CR;
          end else begin
            fmt_err_d = 1'b1;
            msg_d     = MSG_WAIT_D1;
          end
        end
        MSG_WAIT_CR: begin
          if (ch_cr) begin
            bcd1_d  = d1_q;
            bcd0_d  = d0_q;
            valid_d = 1'b1;
          end else begin
            fmt_err_d = 1'b1;
          end
          msg_d = MSG_WAIT_D1;
        end
        default: msg_d = MSG_WAIT_D1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q     <= MSG_WAIT_D1;
      d1_q      <= '0;
      d0_q      <= '0;
      bcd1_q    <= '0;
      bcd0_q    <= '0;
      valid_q   <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      msg_q     <= msg_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      bcd1_q    <= bcd1_d;
      bcd0_q    <= bcd0_d;
      valid_q   <= valid_d;
      fmt_err_q <= fmt_err_d;
    end
  end

  assign bus.bcd1      = bcd1_q;
  assign bus.bcd0      = bcd0_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_w;
  assign bus.fmt_err   = fmt_err_q;

`ifdef UART_RX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Coincident pulses count once; sticks at 255.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((frame_err_w || fmt_err_q) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_uart_bcd_rx.sv
// Directed bench for uart_bcd_rx with a 4-clock bit period.
module tb_uart_bcd_rx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_bcd_rx_if bus();

  uart_bcd_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int tests = 0;
  int fails = 0;

  // Pulse tallies, sampled mid-cycle.
  int n_valid = 0, n_ferr = 0, n_fmt = 0;
  always @(negedge clk) begin
    if (bus.valid)     n_valid <= n_valid + 1;
    if (bus.frame_err) n_ferr  <= n_ferr + 1;
    if (bus.fmt_err)   n_fmt   <= n_fmt + 1;
  end

  int v0, f0, m0;

  task automatic snap();
    v0 = n_valid;
    f0 = n_ferr;
    m0 = n_fmt;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge.
  task automatic bit_out(input logic b);
    bus.rx_in = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] c, input logic stop, input int idle);
    bit_out(1'b0);
    for (int i = 0; i < 7; i++) bit_out(c[i]);
    bit_out(stop);
    for (int i = 0; i < idle; i++) bit_out(1'b1);
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rx_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bcd1", int'(bus.bcd1), 0);
    chk("rst_bcd0", int'(bus.bcd0), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_frame_err", int'(bus.frame_err), 0);
    chk("rst_fmt_err", int'(bus.fmt_err), 0);
`ifdef UART_RX_ERRCNT_EN
    chk("rst_err_cnt", int'(bus.err_cnt), 0);
`endif
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // 1: '4','2',CR then '9','0',CR
    snap();
    send(7'h34, 1'b1, 1); send(7'h32, 1'b1, 1); send(7'h0D, 1'b1, 1);
    settle();
    chk("t1a_valid_cnt", n_valid - v0, 1);
    chk("t1a_bcd1", int'(bus.bcd1), 4);
    chk("t1a_bcd0", int'(bus.bcd0), 2);
    chk("t1a_ferr_cnt", n_ferr - f0, 0);
    chk("t1a_fmt_cnt", n_fmt - m0, 0);
    snap();
    send(7'h39, 1'b1, 1); send(7'h30, 1'b1, 1); send(7'h0D, 1'b1, 1);
    settle();
    chk("t1b_valid_cnt", n_valid - v0, 1);
    chk("t1b_bcd1", int'(bus.bcd1), 9);
    chk("t1b_bcd0", int'(bus.bcd0), 0);

    // 2: '7' with stop bit low, then '5','3',CR
    snap();
    send(7'h37, 1'b0, 1);
    settle();
    chk("t2_ferr_cnt", n_ferr - f0, 1);
    chk("t2_hold_bcd1", int'(bus.bcd1), 9);
    chk("t2_hold_bcd0", int'(bus.bcd0), 0);
    send(7'h35, 1'b1, 1); send(7'h33, 1'b1, 1); send(7'h0D, 1'b1, 1);
    settle();
    chk("t2_valid_cnt", n_valid - v0, 1);
    chk("t2_bcd1", int'(bus.bcd1), 5);
    chk("t2_bcd0", int'(bus.bcd0), 3);
    chk("t2_ferr_total", n_ferr - f0, 1);
    chk("t2_fmt_cnt", n_fmt - m0, 0);

    // 3: '4','A',CR -> two format errors; then '1','2',CR
    snap();
    send(7'h34, 1'b1, 1); send(7'h41, 1'b1, 1); send(7'h0D, 1'b1, 1);
    settle();
    chk("t3_fmt_cnt", n_fmt - m0, 2);
    chk("t3_valid_cnt", n_valid - v0, 0);
    chk("t3_hold_bcd1", int'(bus.bcd1), 5);
    snap();
    send(7'h31, 1'b1, 1); send(7'h32, 1'b1, 1); send(7'h0D, 1'b1, 1);
    settle();
    chk("t3b_valid_cnt", n_valid - v0, 1);
    chk("t3b_bcd1", int'(bus.bcd1), 1);
    chk("t3b_bcd0", int'(bus.bcd0), 2);

    // 4: one-clock low glitch
    snap();
    bus.rx_in = 1'b0;
    @(posedge clk); #1;
    bus.rx_in = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("t4_valid_cnt", n_valid - v0, 0);
    chk("t4_ferr_cnt", n_ferr - f0, 0);
    chk("t4_fmt_cnt", n_fmt - m0, 0);

    // 5: reset during the second character of '8','6',CR
    send(7'h38, 1'b1, 1);
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_rst_bcd1", int'(bus.bcd1), 0);
    chk("t5_rst_bcd0", int'(bus.bcd0), 0);
    chk("t5_rst_valid", int'(bus.valid), 0);
    bus.rx_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk); #1;
    snap();
    send(7'h33, 1'b1, 1); send(7'h31, 1'b1, 1); send(7'h0D, 1'b1, 1);
    settle();
    chk("t5_valid_cnt", n_valid - v0, 1);
    chk("t5_bcd1", int'(bus.bcd1), 3);
    chk("t5_bcd0", int'(bus.bcd0), 1);
    chk("t5_fmt_cnt", n_fmt - m0, 0);

    // 6: '6','6',CR with no idle bits between frames
    snap();
    send(7'h36, 1'b1, 0); send(7'h36, 1'b1, 0); send(7'h0D, 1'b1, 1);
    settle();
    chk("t6_valid_cnt", n_valid - v0, 1);
    chk("t6_bcd1", int'(bus.bcd1), 6);
    chk("t6_bcd0", int'(bus.bcd0), 6);
    chk("t6_ferr_cnt", n_ferr - f0, 0);
    chk("t6_fmt_cnt", n_fmt - m0, 0);

`ifdef UART_RX_ERRCNT_EN
    // 300 framing errors must saturate the counter
    for (int k = 0; k < 300; k++) send(7'h55, 1'b0, 1);
    settle();
    chk("t6_err_cnt_sat", int'(bus.err_cnt), 255);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
